// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter.
// State encoding and counter sizing helper.
package mem_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BUSY_D = 3'd1,
      BUSY_I = 3'd2,
      DUMP   = 3'd3,
      HALTED = 3'd4
   } state_t;

   function automatic int cnt_width(input int lat);
      return $clog2(lat) + 1;
   endfunction

endpackage

// File: rtl/mem_lat_cnt.sv
// Loadable down-counter with zero flag.
// Tracks remaining memory latency cycles.
module mem_lat_cnt #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] init,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= init;
      end else if (dec && cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data > halt > fetch.
// Sequences fixed-latency accesses and the halt dump.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int MEM_LAT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              if_stall,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              d_stall,
   input  logic              halt,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_dump,
   output logic              halted,
   output logic              err
);

   localparam int CW = cnt_width(MEM_LAT);
   localparam logic [CW-1:0] LOAD = CW'(MEM_LAT - 1);

   state_t state, state_nxt;

   logic [ADDR_W-1:0] addr_q, lat_addr;
   logic [DATA_W-1:0] wdata_q, lat_wdata;
   logic              wr_q, lat_wr;
   logic              lat_en;
   logic              err_q, err_set;
   logic              cnt_load, cnt_dec, cnt_zero;

   logic req_d, req_e, req_h, req_i;

   assign req_d = d_rd ^ d_wr;
   assign req_e = d_rd & d_wr;
   assign req_h = ~d_rd & ~d_wr & halt;
   assign req_i = ~d_rd & ~d_wr & ~halt & if_req;

   mem_lat_cnt #(
      .W(CW)
   ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .load (cnt_load),
      .dec  (cnt_dec),
      .init (LOAD),
      .zero (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (lat_en) begin
            addr_q  <= lat_addr;
            wdata_q <= lat_wdata;
            wr_q    <= lat_wr;
         end
         if (err_set) begin
            err_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_dump  = 1'b0;
      lat_en    = 1'b0;
      lat_addr  = '0;
      lat_wdata = '0;
      lat_wr    = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      err_set   = 1'b0;
      if_valid  = 1'b0;
      if_rdata  = '0;
      d_valid   = 1'b0;
      d_rdata   = '0;
      halted    = 1'b0;
      // Outputs stay quiet while reset is asserted.
      if (rst_n) begin
         unique case (state)
            IDLE: begin
               unique case (1'b1)
                  req_d: begin
                     mem_en    = 1'b1;
                     mem_wr    = d_wr;
                     mem_addr  = d_addr;
                     mem_wdata = d_wdata;
                     lat_en    = 1'b1;
                     lat_addr  = d_addr;
                     lat_wdata = d_wdata;
                     lat_wr    = d_wr;
                     cnt_load  = 1'b1;
                     state_nxt = BUSY_D;
                  end
                  req_e: begin
                     err_set   = 1'b1;
                     state_nxt = HALTED;
                  end
                  req_h: begin
                     state_nxt = DUMP;
                  end
                  req_i: begin
                     mem_en    = 1'b1;
                     mem_addr  = if_addr;
                     lat_en    = 1'b1;
                     lat_addr  = if_addr;
                     cnt_load  = 1'b1;
                     state_nxt = BUSY_I;
                  end
                  default: begin
                     state_nxt = IDLE;
                  end
               endcase
            end
            BUSY_D, BUSY_I: begin
               mem_addr  = addr_q;
               mem_wr    = wr_q;
               mem_wdata = wdata_q;
               cnt_dec   = 1'b1;
               if (cnt_zero) begin
                  state_nxt = IDLE;
                  if (state == BUSY_D) begin
                     d_valid = 1'b1;
                     d_rdata = wr_q ? '0 : mem_rdata;
                  end else begin
                     if_valid = 1'b1;
                     if_rdata = mem_rdata;
                  end
               end
            end
            DUMP: begin
               mem_dump  = 1'b1;
               state_nxt = HALTED;
            end
            HALTED: begin
               halted = 1'b1;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   assign err      = err_q;
   assign d_stall  = (d_rd | d_wr) & ~d_valid;
   assign if_stall = if_req & ~if_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a latency memory model.
// Directed plan cases plus randomized fetch/load/store traffic.
module tb_mem_arbiter;

   localparam int L = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, d_rd, d_wr, halt;
   logic [15:0] if_addr, d_addr, d_wdata;
   logic [15:0] if_rdata, d_rdata;
   logic        if_valid, if_stall, d_valid, d_stall;
   logic        mem_en, mem_wr, mem_dump, halted, err;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = 16'h0;

   mem_arbiter #(
      .DATA_W (16),
      .ADDR_W (16),
      .MEM_LAT(L)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_valid (if_valid),
      .if_stall (if_stall),
      .d_rd     (d_rd),
      .d_wr     (d_wr),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .d_valid  (d_valid),
      .d_stall  (d_stall),
      .halt     (halt),
      .mem_en   (mem_en),
      .mem_wr   (mem_wr),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_dump (mem_dump),
      .halted   (halted),
      .err      (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [15:0] addr;
      logic        wr;
      logic [15:0] wdata;
   } iss_t;

   typedef struct {
      int          cyc;
      logic [15:0] addr;
      logic        wr;
      logic [15:0] wdata;
      logic [15:0] data;
   } rsp_t;

   iss_t exp_iss[$];
   rsp_t exp_d[$];
   rsp_t exp_i[$];
   int   exp_dump[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [15:0] store[logic [15:0]];
   logic [15:0] ref_mem[logic [15:0]];
   logic [15:0] slot[16];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, req, cyc);
      end
   endtask

   function automatic logic [15:0] init_val(input logic [15:0] a);
      return a ^ 16'hA5C3;
   endfunction

   function automatic logic [15:0] ref_read(input logic [15:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_val(a);
   endfunction

   // Memory: accepts a strobe, returns read data L cycles later.
   always @(negedge clk) begin
      if (mem_en) begin
         if (mem_wr) store[mem_addr] = mem_wdata;
         else slot[(cyc + L) % 16] = store.exists(mem_addr) ?
                                     store[mem_addr] : init_val(mem_addr);
      end
   end

   always @(posedge clk) begin
      cyc = cyc + 1;
      mem_rdata = slot[cyc % 16];
      slot[cyc % 16] = 16'($urandom);
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (mem_en) begin
         if (exp_iss.size() == 0) begin
            chk("spurious_mem_en", {31'd0, mem_en}, 32'd0);
         end else begin
            iss_t e;
            e = exp_iss.pop_front();
            chk("issue_cycle", cyc, e.cyc);
            chk("issue_addr", {16'd0, mem_addr}, {16'd0, e.addr});
            chk("issue_wr", {31'd0, mem_wr}, {31'd0, e.wr});
            if (e.wr) chk("issue_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
         end
      end
      if (d_valid) begin
         if (exp_d.size() == 0) begin
            chk("spurious_d_valid", {31'd0, d_valid}, 32'd0);
         end else begin
            rsp_t r;
            r = exp_d.pop_front();
            chk("d_valid_cycle", cyc, r.cyc);
            chk("d_rdata", {16'd0, d_rdata}, {16'd0, r.data});
            chk("d_stall_at_valid", {31'd0, d_stall}, 32'd0);
            chk("d_addr_held", {16'd0, mem_addr}, {16'd0, r.addr});
            chk("d_wr_held", {31'd0, mem_wr}, {31'd0, r.wr});
            if (r.wr) chk("d_wdata_held", {16'd0, mem_wdata}, {16'd0, r.wdata});
         end
      end
      if (if_valid) begin
         if (exp_i.size() == 0) begin
            chk("spurious_if_valid", {31'd0, if_valid}, 32'd0);
         end else begin
            rsp_t r;
            r = exp_i.pop_front();
            chk("if_valid_cycle", cyc, r.cyc);
            chk("if_rdata", {16'd0, if_rdata}, {16'd0, r.data});
            chk("if_stall_at_valid", {31'd0, if_stall}, 32'd0);
            chk("if_addr_held", {16'd0, mem_addr}, {16'd0, r.addr});
         end
      end
      if (mem_dump) begin
         if (exp_dump.size() == 0) chk("spurious_dump", {31'd0, mem_dump}, 32'd0);
         else chk("dump_cycle", cyc, exp_dump.pop_front());
      end
   end

   task automatic clear_inputs();
      if_req = 1'b0; if_addr = '0;
      d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
      halt = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
      chk({tag, "_mem_bus"}, {mem_addr, mem_wdata}, 32'd0);
      chk({tag, "_valids"}, {30'd0, if_valid, d_valid}, 32'd0);
      chk({tag, "_rdata"}, {if_rdata, d_rdata}, 32'd0);
      chk({tag, "_flags"}, {28'd0, mem_wr, mem_dump, halted, err}, 32'd0);
      chk({tag, "_stalls"}, {30'd0, if_stall, d_stall}, 32'd0);
   endtask

   task automatic wait_valid(input bit sel);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (sel ? if_valid : d_valid) seen = 1;
         else @(negedge clk);
      end
      chk(sel ? "if_valid_timeout" : "d_valid_timeout",
          {31'd0, seen}, 32'd1);
   endtask

   // dop: 0 none, 1 load, 2 store
   task automatic do_txn(input int dop, input bit fetch,
                         input logic [15:0] da, input logic [15:0] wd,
                         input logic [15:0] fa);
      int t0, tf;
      iss_t is;
      rsp_t rs;
      @(posedge clk); #1;
      t0 = cyc;
      d_rd = (dop == 1); d_wr = (dop == 2);
      d_addr = da; d_wdata = wd;
      if_req = fetch; if_addr = fa;
      tf = t0;
      if (dop != 0) begin
         is = '{t0, da, dop == 2, wd};
         exp_iss.push_back(is);
         rs = '{t0 + L, da, dop == 2, wd, (dop == 2) ? 16'h0 : ref_read(da)};
         exp_d.push_back(rs);
         if (dop == 2) ref_mem[da] = wd;
         tf = t0 + L + 1;
      end
      if (fetch) begin
         is = '{tf, fa, 1'b0, 16'h0};
         exp_iss.push_back(is);
         rs = '{tf + L, fa, 1'b0, 16'h0, ref_read(fa)};
         exp_i.push_back(rs);
      end
      @(negedge clk);
      if (dop != 0) chk("d_stall_issue", {31'd0, d_stall}, 32'd1);
      if (fetch) chk("if_stall_issue", {31'd0, if_stall}, 32'd1);
      if (dop != 0) begin
         wait_valid(1'b0);
         @(posedge clk); #1;
         d_rd = 1'b0; d_wr = 1'b0;
         if (fetch) begin
            @(negedge clk);
            chk("if_stall_behind_data", {31'd0, if_stall}, 32'd1);
         end
      end
      if (fetch) begin
         wait_valid(1'b1);
         @(posedge clk); #1;
         if_req = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      iss_t is;
      for (int i = 0; i < 16; i++) slot[i] = 16'h0;
      rst_n = 1'b0;
      clear_inputs();
      store[16'h0010] = 16'hC123;
      ref_mem[16'h0010] = 16'hC123;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_quiet("reset");

      do_txn(0, 1'b1, 16'h0, 16'h0, 16'h0010);
      do_txn(1, 1'b1, 16'h0200, 16'h0, 16'h0010);
      do_txn(2, 1'b0, 16'h0300, 16'hBEEF, 16'h0);
      do_txn(1, 1'b0, 16'h0300, 16'h0, 16'h0);

      for (int n = 0; n < 30; n++) begin
         int dop;
         bit fe;
         dop = $urandom_range(0, 2);
         fe = 1'($urandom_range(0, 1));
         if (dop == 0) fe = 1'b1;
         do_txn(dop, fe, 16'h0200 + 16'($urandom_range(0, 7)),
                16'($urandom), 16'h0200 + 16'($urandom_range(0, 7)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      // Reset in the middle of a fetch abandons it.
      @(posedge clk); #1;
      t0 = cyc;
      if_req = 1'b1; if_addr = 16'h0044;
      is = '{t0, 16'h0044, 1'b0, 16'h0};
      exp_iss.push_back(is);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      if_req = 1'b0;
      @(negedge clk);
      chk_quiet("after_midreset");
      repeat (8) @(negedge clk);
      do_txn(0, 1'b1, 16'h0, 16'h0, 16'h0010);

      // Halt raised while a data access is in flight.
      @(posedge clk); #1;
      t0 = cyc;
      d_rd = 1'b1; d_addr = 16'h0205;
      is = '{t0, 16'h0205, 1'b0, 16'h0};
      exp_iss.push_back(is);
      exp_d.push_back('{t0 + L, 16'h0205, 1'b0, 16'h0, ref_read(16'h0205)});
      exp_dump.push_back(t0 + L + 2);
      @(posedge clk); #1;
      halt = 1'b1;
      @(negedge clk);
      wait_valid(1'b0);
      @(posedge clk); #1;
      d_rd = 1'b0;
      @(negedge clk);
      chk("halted_before_dump", {31'd0, halted}, 32'd0);
      repeat (2) @(negedge clk);
      chk("halted_set", {31'd0, halted}, 32'd1);
      chk("halt_cycle", cyc, t0 + L + 3);
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 16'h0010;
      repeat (6) begin
         @(negedge clk);
         chk("halted_if_stall", {30'd0, if_stall, halted}, 32'd3);
      end
      do_reset();
      @(negedge clk);
      chk_quiet("after_halt_reset");

      // Simultaneous load and store is a protocol error.
      @(posedge clk); #1;
      d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0210;
      @(negedge clk);
      chk("conflict_no_issue", {31'd0, mem_en}, 32'd0);
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      chk("conflict_err", {30'd0, err, halted}, 32'd3);
      repeat (4) @(negedge clk);
      chk("err_sticky", {31'd0, err}, 32'd1);
      do_reset();
      @(negedge clk);
      chk_quiet("after_err_reset");
      do_txn(1, 1'b1, 16'h0300, 16'h0, 16'h0200);

      repeat (L + 4) @(negedge clk);
      chk("pending_issue", exp_iss.size(), 0);
      chk("pending_d", exp_d.size(), 0);
      chk("pending_i", exp_i.size(), 0);
      chk("pending_dump", exp_dump.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
